xspi_bank_ctrl: RTL and testbench



---
 rtl/xspi_bank_ctrl_pkg.sv | 10 +
 rtl/xspi_bank_ctrl_shifter.sv | 61 ++++++
 rtl/xspi_bank_ctrl.sv | 82 ++++++++
 tb/tb_xspi_bank_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xspi_bank_ctrl_pkg.sv
// xspi_bank_ctrl_pkg: ctrl field positions, port addresses and shifter states
package xspi_bank_ctrl_pkg;
  localparam int CTRL_PEN    = 0;
  localparam int CTRL_START  = 1;
  localparam int CTRL_CPHASE = 4;
  localparam int CTRL_ZP     = 5;
  localparam logic [15:0] PORT_STAT = 16'h0000;
  localparam logic [15:0] PORT_RX   = 16'h0001;
  typedef enum logic {IDLE, SHIFT} shift_state_t;
endpackage

// File: rtl/xspi_bank_ctrl_shifter.sv
// xspi_bank_ctrl_shifter: SPI mode-0 MSB-first byte shifter with SCK divider
module xspi_bank_ctrl_shifter
  import xspi_bank_ctrl_pkg::*;
#(
  parameter int CLKDIV = 1
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       MISO,
  output logic       SCK,
  output logic       MOSI,
  output logic       BUSY,
  output logic [7:0] rx
);
  shift_state_t state, state_nx;
  logic [3:0] cnt;
  logic [2:0] bitn;
  logic [6:0] sr;
  logic tick, last;
  assign tick = cnt == 4'(CLKDIV - 1);
  assign last = tick && SCK && bitn == 3'd7;
  assign BUSY = state == SHIFT;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && start) ? SHIFT : (state == SHIFT && last) ? IDLE : state;
  end
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      cnt  <= '0;
      bitn <= '0;
      sr   <= '0;
      SCK  <= 1'b0;
      MOSI <= 1'b0;
      rx   <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        sr   <= tx[6:0];
        MOSI <= tx[7];
        SCK  <= 1'b0;
        cnt  <= '0;
        bitn <= '0;
      end
    end else begin
      cnt <= tick ? '0 : cnt + 4'd1;
      if (tick) begin
        SCK <= !SCK;
        if (!SCK) rx <= {rx[6:0], MISO};
        else if (bitn != 3'd7) begin
          bitn <= bitn + 3'd1;
          MOSI <= sr[6];
          sr   <= {sr[5:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: rtl/xspi_bank_ctrl.sv
// xspi_bank_ctrl: Gigatron expansion ctrl decoder with RAM banking, chip selects
// and a hardware SPI byte shifter alongside the bit-bang path.
module xspi_bank_ctrl
  import xspi_bank_ctrl_pkg::*;
#(
  parameter int BANK_BITS = 2,
  parameter int NSS       = 2,
  parameter int CLKDIV    = 1
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic [15:0]           GA,
  input  logic                  nGOE,
  input  logic                  nGWE,
  input  logic [7:0]            GBUSIN,
  output logic [7:0]            GBUSOUT,
  output logic [14+BANK_BITS:0] RA,
  input  logic [7:0]            RDIN,
  output logic [7:0]            RDOUT,
  output logic                  nROE,
  output logic                  nRWE,
  output logic                  nACTRL,
  output logic                  SCK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic [NSS-1:0]        nSS,
  output logic                  BUSY
);
  logic ctrl, ctrl_d, fire, start, nzp, pen, sck_m, mosi_m, sh_sck, sh_mosi, be, hit_stat, hit_rx;
  logic [BANK_BITS-1:0] bank;
  logic [3:0] bank_sel, bank4;
  logic [1:0] ss_sel;
  logic [7:0] rx;
  assign ctrl     = !nGOE && !nGWE && GA[3:2] != 2'b00;
  assign fire     = ctrl && !ctrl_d;
  assign start    = fire && GA[CTRL_START] && !BUSY;
  assign bank_sel = {GA[13], GA[12], GA[7], GA[6]};
  assign ss_sel   = GA[3:2];
  assign bank4    = 4'(bank);
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      ctrl_d <= 1'b0;
      bank   <= '0;
      nzp    <= 1'b1;
      pen    <= 1'b0;
      nSS    <= '1;
      sck_m  <= 1'b0;
      mosi_m <= 1'b0;
    end else begin
      ctrl_d <= ctrl;
      if (fire && !GA[CTRL_START]) begin
        bank <= bank_sel[BANK_BITS-1:0];
        nzp  <= GA[CTRL_ZP];
        pen  <= GA[CTRL_PEN];
        if (!BUSY) begin
          nSS    <= ss_sel[NSS-1:0];
          sck_m  <= GA[CTRL_PEN] ~^ GA[CTRL_CPHASE];
          mosi_m <= GA[15];
        end
      end else if (start) begin
        // leave the bit-bang path where the shifter will finish: SCK low, MOSI = tx[0]
        sck_m  <= 1'b0;
        mosi_m <= GA[8];
      end
    end
  end
  xspi_bank_ctrl_shifter #(.CLKDIV(CLKDIV)) u_shifter (
    .CLK(CLK), .nRESET(nRESET), .start(start), .tx(GA[15:8]), .MISO(MISO),
    .SCK(sh_sck), .MOSI(sh_mosi), .BUSY(BUSY), .rx(rx)
  );
  assign SCK      = BUSY ? sh_sck : sck_m;
  assign MOSI     = BUSY ? sh_mosi : mosi_m;
  assign be       = GA[15] ^ (GA[14:7] == 8'h01 && !nzp);
  assign RA       = {be ? bank : '0, GA[14:0]};
  assign hit_stat = pen && !nGOE && GA == PORT_STAT;
  assign hit_rx   = pen && !nGOE && GA == PORT_RX;
  assign GBUSOUT  = hit_stat ? {bank4[1:0], BUSY, 4'b0000, MISO} : hit_rx ? rx : RDIN;
  assign RDOUT    = GBUSIN;
  assign nROE     = nGOE | hit_stat | hit_rx;
  assign nRWE     = nGWE | !nGOE;
  assign nACTRL   = nGOE | nGWE | (GA[3:2] != 2'b00);
endmodule

// File: tb/tb_xspi_bank_ctrl.sv
// tb_xspi_bank_ctrl: randomized checks against a behavioural model, with an SPI slave
module tb_xspi_bank_ctrl;
  localparam int CLKDIV = 2;
  logic CLK = 1'b0, nRESET = 1'b0, nGOE = 1'b1, nGWE = 1'b1, miso_force = 1'b0, slave_on = 1'b0, MISO;
  logic [15:0] GA = '0;
  logic [7:0] GBUSIN = '0, RDIN = '0, pat = '0, cap = '0;
  logic [7:0] gbusout, rdout, gbusout4, rdout4;
  logic [16:0] ra;
  logic [18:0] ra4;
  logic [1:0] nss, nss4;
  logic nroe, nrwe, nactrl, sck, mosi, busy, nroe4, nrwe4, nactrl4, sck4, mosi4, busy4;
  int cyc = 0, rises = 0, falls = 0, rise_base = 0, fall_base = 0, idx;
  int checks = 0, errors = 0;
  logic [3:0] m_bank4 = '0;
  logic m_nzp = 1'b1, m_pen = 1'b0, m_sck = 1'b0, m_mosi = 1'b0;
  logic [1:0] m_nss = 2'b11;
  logic [7:0] m_rx = '0;
  int m_start = -1000;

  xspi_bank_ctrl #(.BANK_BITS(2), .NSS(2), .CLKDIV(CLKDIV)) dut (
    .CLK(CLK), .nRESET(nRESET), .GA(GA), .nGOE(nGOE), .nGWE(nGWE), .GBUSIN(GBUSIN),
    .GBUSOUT(gbusout), .RA(ra), .RDIN(RDIN), .RDOUT(rdout), .nROE(nroe), .nRWE(nrwe),
    .nACTRL(nactrl), .SCK(sck), .MOSI(mosi), .MISO(MISO), .nSS(nss), .BUSY(busy));
  xspi_bank_ctrl #(.BANK_BITS(4), .NSS(2), .CLKDIV(CLKDIV)) dut4 (
    .CLK(CLK), .nRESET(nRESET), .GA(GA), .nGOE(nGOE), .nGWE(nGWE), .GBUSIN(GBUSIN),
    .GBUSOUT(gbusout4), .RA(ra4), .RDIN(RDIN), .RDOUT(rdout4), .nROE(nroe4), .nRWE(nrwe4),
    .nACTRL(nactrl4), .SCK(sck4), .MOSI(mosi4), .MISO(MISO), .nSS(nss4), .BUSY(busy4));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  // SPI slave: captures MOSI on SCK rise, presents the next pattern bit after each SCK fall
  always @(posedge sck) begin
    rises <= rises + 1;
    cap <= {cap[6:0], mosi};
  end
  always @(negedge sck) falls <= falls + 1;
  always_comb begin
    idx = 7 - (falls - fall_base);
    MISO = miso_force;
    if (slave_on) MISO = (idx >= 0 && idx < 8) ? pat[idx[2:0]] : 1'b0;
  end

  function automatic logic busy_now();
    return m_start <= cyc && cyc < m_start + 16 * CLKDIV;
  endfunction

  task automatic model_reset();
    m_bank4 = '0; m_nzp = 1'b1; m_pen = 1'b0; m_nss = 2'b11;
    m_sck = 1'b0; m_mosi = 1'b0; m_rx = '0; m_start = -1000;
  endtask

  task automatic ctrl_cycle(input logic [15:0] a);
    int e;
    logic bz, acc;
    @(negedge CLK);
    e = cyc + 1;
    bz = m_start < e && e <= m_start + 16 * CLKDIV;
    acc = 1'b0;
    GA = a; nGOE = 1'b0; nGWE = 1'b0;
    if (!a[1]) begin
      m_bank4 = {a[13], a[12], a[7], a[6]}; m_nzp = a[5]; m_pen = a[0];
      if (!bz) begin m_nss = a[3:2]; m_sck = a[0] ~^ a[4]; m_mosi = a[15]; end
    end else if (!bz) begin
      acc = 1'b1; m_start = e; m_sck = 1'b0; m_mosi = a[8]; m_rx = pat;
    end
    @(negedge CLK);
    nGOE = 1'b1; nGWE = 1'b1;
    if (acc) begin rise_base = rises; fall_base = falls; slave_on = 1'b1; end
  endtask

  task automatic test_reset();
    nRESET = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (nss !== 2'b11) begin errors++; $display("FAIL reset_nss got %b exp 11", nss); end
    checks++; if (sck !== 1'b0 || mosi !== 1'b0) begin errors++; $display("FAIL reset_spi got sck=%b mosi=%b exp 0 0", sck, mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    GA = 16'h8000; nGOE = 1'b0; RDIN = 8'h5A; #1;
    checks++; if (ra !== 17'h0 || ra4 !== 19'h0) begin errors++; $display("FAIL reset_ra got %h/%h exp 0/0", ra, ra4); end
    GA = 16'h0000; #1;
    checks++; if (gbusout !== 8'h5A || nroe !== 1'b0) begin errors++; $display("FAIL reset_port got %h nroe=%b exp 5a 0", gbusout, nroe); end
    nGOE = 1'b1;
    @(negedge CLK);
    nRESET = 1'b1;
    model_reset();
  endtask

  task automatic test_config();
    logic [15:0] a, ga;
    logic goe, gwe, be, mf;
    logic [7:0] rd, gi, exp_gb;
    ctrl_cycle(16'h00CD);
    checks++; if (nss !== m_nss || sck !== m_sck || mosi !== m_mosi) begin errors++; $display("FAIL cfg_cd got nss=%b sck=%b mosi=%b exp %b %b %b", nss, sck, mosi, m_nss, m_sck, m_mosi); end
    GA = 16'h0080; nGOE = 1'b0; #1;
    checks++; if (ra[16:15] !== 2'b11) begin errors++; $display("FAIL cfg_zp_ra got %b exp 11", ra[16:15]); end
    nGOE = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a = 16'($urandom); a[1] = 1'b0;
      if (a[3:2] == 2'b00) a[2] = 1'b1;
      ctrl_cycle(a);
      checks++; if (nss !== m_nss || sck !== m_sck || mosi !== m_mosi) begin errors++; $display("FAIL cfg_rand ga=%h got nss=%b sck=%b mosi=%b exp %b %b %b", a, nss, sck, mosi, m_nss, m_sck, m_mosi); end
      for (int j = 0; j < 4; j++) begin
        ga = 16'($urandom);
        if (j == 0) ga = 16'($urandom_range(0, 1));
        if (j == 1) ga = {1'($urandom), 8'h01, 7'($urandom)};
        goe = 1'($urandom); gwe = 1'($urandom);
        if (!goe && !gwe) ga[3:2] = 2'b00;
        rd = 8'($urandom); gi = 8'($urandom); mf = 1'($urandom);
        GA = ga; nGOE = goe; nGWE = gwe; RDIN = rd; GBUSIN = gi; miso_force = mf; #1;
        be = ga[15] ^ (ga[14:7] == 8'h01 && !m_nzp);
        exp_gb = (m_pen && !goe && ga == 16'h0000) ? {m_bank4[1:0], busy_now(), 4'b0000, mf} :
                 (m_pen && !goe && ga == 16'h0001) ? m_rx : rd;
        checks++; if (ra !== {be ? m_bank4[1:0] : 2'b00, ga[14:0]} || ra4 !== {be ? m_bank4 : 4'b0000, ga[14:0]}) begin errors++; $display("FAIL ra ga=%h got %h/%h bank=%b nzp=%b", ga, ra, ra4, m_bank4, m_nzp); end
        checks++; if (gbusout !== exp_gb || rdout !== gi) begin errors++; $display("FAIL gbus ga=%h got %h rdout=%h exp %h %h", ga, gbusout, rdout, exp_gb, gi); end
        checks++; if (nroe !== (goe | (m_pen && ga < 16'd2)) || nrwe !== (gwe | !goe) || nactrl !== (goe | gwe | (ga[3:2] != 2'b00))) begin errors++; $display("FAIL strobes ga=%h oe=%b we=%b got nroe=%b nrwe=%b nactrl=%b", ga, goe, gwe, nroe, nrwe, nactrl); end
      end
      nGOE = 1'b1; nGWE = 1'b1;
    end
  endtask

  task automatic test_ports();
    ctrl_cycle(16'h0085);
    miso_force = 1'b1; RDIN = 8'h77; GA = 16'h0000; nGOE = 1'b0; #1;
    checks++; if (gbusout !== 8'h81 || nroe !== 1'b1) begin errors++; $display("FAIL port0 got %h nroe=%b exp 81 1", gbusout, nroe); end
    nGOE = 1'b1;
    ctrl_cycle(16'h0084);
    GA = 16'h0000; nGOE = 1'b0; #1;
    checks++; if (gbusout !== 8'h77 || nroe !== 1'b0) begin errors++; $display("FAIL port0_nopen got %h nroe=%b exp 77 0", gbusout, nroe); end
    nGOE = 1'b1;
  endtask

  task automatic test_transfer(input logic [15:0] a, input logic [7:0] p);
    int n;
    ctrl_cycle(16'h000D);
    pat = p;
    ctrl_cycle(a);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin n++; @(negedge CLK); end
    checks++; if (n != 16 * CLKDIV) begin errors++; $display("FAIL xfer_busy_len got %0d exp %0d", n, 16 * CLKDIV); end
    checks++; if (rises - rise_base != 8 || cap !== a[15:8]) begin errors++; $display("FAIL xfer_mosi got %0d rises cap=%h exp 8 %h", rises - rise_base, cap, a[15:8]); end
    checks++; if (sck !== 1'b0 || mosi !== a[8]) begin errors++; $display("FAIL xfer_end got sck=%b mosi=%b exp 0 %b", sck, mosi, a[8]); end
    GA = 16'h0001; nGOE = 1'b0; #1;
    checks++; if (gbusout !== p) begin errors++; $display("FAIL xfer_rx got %h exp %h", gbusout, p); end
    nGOE = 1'b1; slave_on = 1'b0;
  endtask

  task automatic test_busy();
    int n;
    ctrl_cycle(16'h000D);
    pat = 8'h96;
    ctrl_cycle(16'h5A0E);
    repeat (3) @(negedge CLK);
    ctrl_cycle(16'h20C5);
    checks++; if (nss !== 2'b11 || busy !== 1'b1) begin errors++; $display("FAIL busy_cfg_nss got %b busy=%b exp 11 1", nss, busy); end
    GA = 16'h8000; nGOE = 1'b0; #1;
    checks++; if (ra[16:15] !== 2'b11 || ra4[18:15] !== 4'b1011) begin errors++; $display("FAIL busy_cfg_bank got %b/%b exp 11/1011", ra[16:15], ra4[18:15]); end
    nGOE = 1'b1;
    ctrl_cycle(16'hFF06);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin n++; @(negedge CLK); end
    checks++; if (busy !== 1'b0 || cap !== 8'h5A) begin errors++; $display("FAIL busy_restart got busy=%b cap=%h exp 0 5a", busy, cap); end
    GA = 16'h0001; nGOE = 1'b0; #1;
    checks++; if (gbusout !== 8'h96) begin errors++; $display("FAIL busy_rx got %h exp 96", gbusout); end
    nGOE = 1'b1;
    pat = 8'hC3;
    ctrl_cycle(16'h3306);
    n = 0;
    while (cyc != m_start + 16 * CLKDIV - 2 && n < 1000) begin n++; @(negedge CLK); end
    ctrl_cycle(16'h0015);
    checks++; if (nss !== m_nss || sck !== m_sck || mosi !== m_mosi || busy !== 1'b0) begin errors++; $display("FAIL fall_edge got nss=%b sck=%b mosi=%b busy=%b exp %b %b %b 0", nss, sck, mosi, busy, m_nss, m_sck, m_mosi); end
    GA = 16'h0001; nGOE = 1'b0; #1;
    checks++; if (gbusout !== 8'hC3) begin errors++; $display("FAIL fall_edge_rx got %h exp c3", gbusout); end
    nGOE = 1'b1; slave_on = 1'b0;
  endtask

  task automatic test_hold();
    int rb;
    @(negedge CLK);
    rb = rises; slave_on = 1'b0; miso_force = 1'b1;
    GA = 16'h1206; nGOE = 1'b0; nGWE = 1'b0;
    m_start = cyc + 1; m_sck = 1'b0; m_mosi = 1'b0; m_rx = 8'hFF;
    repeat (16 * CLKDIV + 6) @(negedge CLK);
    nGOE = 1'b1; nGWE = 1'b1;
    checks++; if (busy !== 1'b0 || rises - rb != 8) begin errors++; $display("FAIL hold_once got busy=%b rises=%0d exp 0 8", busy, rises - rb); end
    GA = 16'h0001; nGOE = 1'b0; #1;
    checks++; if (gbusout !== m_rx || mosi !== m_mosi) begin errors++; $display("FAIL hold_rx got %h mosi=%b exp %h %b", gbusout, mosi, m_rx, m_mosi); end
    nGOE = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    pat = 8'hE7;
    ctrl_cycle(16'h6C0E);
    n = 0;
    while (rises - rise_base < 4 && n < 500) begin n++; @(negedge CLK); end
    checks++; if (n >= 500) begin errors++; $display("FAIL rstmid_wait got %0d rises exp 4", rises - rise_base); end
    #2 nRESET = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || sck !== 1'b0 || nss !== 2'b11 || mosi !== 1'b0) begin errors++; $display("FAIL rstmid got busy=%b sck=%b nss=%b mosi=%b exp 0 0 11 0", busy, sck, nss, mosi); end
    model_reset();
    slave_on = 1'b0;
    @(negedge CLK);
    nRESET = 1'b1;
    ctrl_cycle(16'h000D);
    GA = 16'h0001; nGOE = 1'b0; #1;
    checks++; if (gbusout !== 8'h00) begin errors++; $display("FAIL rstmid_rx got %h exp 00", gbusout); end
    nGOE = 1'b1;
  endtask

  task automatic test_bank4();
    ctrl_cycle(16'h2044);
    GA = 16'h8000; nGOE = 1'b0; #1;
    checks++; if (ra4[18:15] !== 4'b1001 || ra[16:15] !== 2'b01) begin errors++; $display("FAIL bank4 got %b/%b exp 1001/01", ra4[18:15], ra[16:15]); end
    GA = 16'h8080; #1;
    checks++; if (ra4[18:15] !== 4'b0000) begin errors++; $display("FAIL bank4_zp_hi got %b exp 0000", ra4[18:15]); end
    GA = 16'h0080; #1;
    checks++; if (ra4[18:15] !== 4'b1001) begin errors++; $display("FAIL bank4_zp got %b exp 1001", ra4[18:15]); end
    nGOE = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_config();
    test_ports();
    test_transfer(16'hA506, 8'h3C);
    for (int k = 0; k < 4; k++)
      test_transfer({8'($urandom), 4'($urandom), 2'($urandom_range(1, 3)), 2'b10}, 8'($urandom));
    test_busy();
    test_hold();
    test_reset_mid();
    test_transfer(16'h6C0E, 8'hE7);
    test_bank4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
